// File: rtl/spi_xfer_arb.sv
// spi_xfer_arb: round-robin sequencer/arbiter in front of the SPI transfer core.
// It grants one requester at a time, latches that requester's descriptor onto
// the core config outputs, pulses the length load, holds start for the whole
// transfer and routes the tx/rx word streams. The core is released only after
// it reports last and drops busy.
// Optional build macro SPI_XFER_ARB_TIMEOUT_EN adds an inactivity watchdog
// that forces completion; without it timeout_o is tied low.
module spi_xfer_arb #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int TRL_WIDTH   = 8,
  parameter int CAL_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic [NUM_REQ-1:0]                          req_valid_i,
  output logic [NUM_REQ-1:0]                          req_ready_o,
  input  logic [NUM_REQ*(11+CAL_WIDTH+TRL_WIDTH)-1:0] req_desc_i,
  input  logic [NUM_REQ-1:0]                          req_tx_valid_i,
  output logic [NUM_REQ-1:0]                          req_tx_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]               req_tx_data_i,
  output logic [NUM_REQ-1:0]                          req_rx_valid_o,
  input  logic [NUM_REQ-1:0]                          req_rx_ready_i,
  output logic [DATA_WIDTH-1:0]                       req_rx_data_o,
  output logic [NUM_REQ-1:0]                          req_done_o,
  output logic [NUM_REQ-1:0]                          grant_o,
  output logic                                        rx_drop_o,
  output logic                                        timeout_o,
  output logic                                        core_st_o,
  output logic                                        core_trl_valid_o,
  output logic [TRL_WIDTH-1:0]                        core_trl_o,
  output logic                                        core_rwm_o,
  output logic [1:0]                                  core_spm_o,
  output logic [3:0]                                  core_snm_o,
  output logic [1:0]                                  core_tdtb_o,
  output logic [1:0]                                  core_rdtb_o,
  output logic [CAL_WIDTH-1:0]                        core_cal_o,
  input  logic                                        core_busy_i,
  input  logic                                        core_last_i,
  output logic                                        core_tx_valid_o,
  input  logic                                        core_tx_ready_i,
  output logic [DATA_WIDTH-1:0]                       core_tx_data_o,
  input  logic                                        core_rx_valid_i,
  output logic                                        core_rx_ready_o,
  input  logic [DATA_WIDTH-1:0]                       core_rx_data_i
);

  localparam int DW    = 11 + CAL_WIDTH + TRL_WIDTH;
  localparam int OFS   = TRL_WIDTH + CAL_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [DW-1:0]    desc_q, desc_d;
  logic             drain_q, drain_d;

  logic [2*NUM_REQ-1:0] rot_vld;
  logic [IDX_W-1:0]     pick;
  logic                 pick_vld;
  logic [IDX_W:0]       pick_sum;
  logic [IDX_W:0]       own_inc;
  logic [IDX_W-1:0]     rr_next;
  logic [DW-1:0]        desc_sel;

  logic tmo_hit;
  logic tmo_q;

  // Rotate requests so bit 0 is the requester the RR pointer currently favours.
  assign rot_vld = {req_valid_i, req_valid_i} >> rr_q;

  // First requesting index at or after the RR pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    pick_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_vld[i]) begin
        pick_vld = 1'b1;
        pick_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
        if (pick_sum >= (IDX_W+1)'(NUM_REQ)) begin
          pick = IDX_W'(pick_sum - (IDX_W+1)'(NUM_REQ));
        end else begin
          pick = IDX_W'(pick_sum);
        end
      end
    end
  end

  // Descriptor of the requester about to be granted.
  always_comb begin
    desc_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) desc_sel = req_desc_i[i*DW +: DW];
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    own_inc = {1'b0, owner_q} + (IDX_W+1)'(1);
    rr_next = (own_inc >= (IDX_W+1)'(NUM_REQ)) ? '0 : IDX_W'(own_inc);
  end

  // State and latched-descriptor registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      desc_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      desc_q  <= desc_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; drain_q marks that DRAIN has already lasted one cycle.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    desc_d  = desc_q;
    drain_d = (state_q == S_DRAIN);
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          desc_d  = desc_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = core_last_i ? S_DRAIN : S_RUN;
      S_RUN: begin
        if (core_last_i || tmo_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q && (!core_busy_i || tmo_q || tmo_hit)) state_d = S_DONE;
      end
      S_DONE: begin
        rr_d    = rr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and owner; rx stays routed through DRAIN.
  always_comb begin
    req_ready_o      = '0;
    grant_o          = '0;
    req_done_o       = '0;
    req_tx_ready_o   = '0;
    req_rx_valid_o   = '0;
    req_rx_data_o    = '0;
    rx_drop_o        = 1'b0;
    timeout_o        = 1'b0;
    core_st_o        = (state_q == S_START) || (state_q == S_RUN);
    core_trl_valid_o = (state_q == S_LOAD);
    core_trl_o       = (state_q == S_LOAD) ? desc_q[TRL_WIDTH-1:0] : '0;
    core_tx_valid_o  = 1'b0;
    core_tx_data_o   = '0;
    core_rx_ready_o  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == S_IDLE && rst_n_i && pick_vld && pick == IDX_W'(i)) begin
        req_ready_o[i] = 1'b1;
      end
      if (owner_q == IDX_W'(i)) begin
        if (state_q inside {S_LOAD, S_START, S_RUN, S_DRAIN}) grant_o[i] = 1'b1;
        if (state_q == S_RUN) begin
          core_tx_valid_o   = req_tx_valid_i[i];
          core_tx_data_o    = req_tx_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          req_tx_ready_o[i] = core_tx_ready_i;
        end
        if (state_q == S_RUN || state_q == S_DRAIN) begin
          req_rx_valid_o[i] = core_rx_valid_i;
          core_rx_ready_o   = req_rx_ready_i[i];
          req_rx_data_o     = core_rx_data_i;
          rx_drop_o         = core_rx_valid_i && !req_rx_ready_i[i];
        end
        if (state_q == S_DONE) begin
          req_done_o[i] = 1'b1;
          timeout_o     = tmo_q;
        end
      end
    end
  end

  assign core_rwm_o  = desc_q[OFS+10];
  assign core_spm_o  = desc_q[OFS+8 +: 2];
  assign core_snm_o  = desc_q[OFS+4 +: 4];
  assign core_tdtb_o = desc_q[OFS+2 +: 2];
  assign core_rdtb_o = desc_q[OFS +: 2];
  assign core_cal_o  = desc_q[TRL_WIDTH +: CAL_WIDTH];

`ifdef SPI_XFER_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_d;
  logic        xfer_hs;

  assign xfer_hs = (core_tx_valid_o && core_tx_ready_i) ||
                   (core_rx_valid_i && core_rx_ready_o);
  assign tmo_hit = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                   (tmo_cnt_q >= TMO_LIM);

  // Inactivity counter: restarts on RUN entry and on any word handshake.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_q;
    if ((state_q != S_RUN && state_d == S_RUN) || xfer_hs) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_RUN || state_q == S_DRAIN) && tmo_cnt_q < TMO_LIM) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
    if (state_q == S_IDLE) begin
      tmo_flag_d = 1'b0;
    end else if (tmo_hit) begin
      tmo_flag_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_flag_d;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign tmo_q          = 1'b0;
  assign unused_tmo_cfg = |TIMEOUT_CYC;
`endif

endmodule

// File: doc/spi_xfer_arb.md
Name: spi_xfer_arb

Overview:
- Sequencer and arbiter in front of the SPI transfer core.
- Accepts transfer descriptors from NUM_REQ requesters (e.g. register-FIFO path, XIP read path) and grants one at a time, round-robin.
- For the granted requester it programs the core's static config, pulses the transfer-length load, holds start for the whole transfer, and routes tx/rx word streams.
- Releases the core only after the core reports last and deasserts busy.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 32, tx/rx word width.
- TRL_WIDTH, 8, transfer-length field width.
- CAL_WIDTH, 8, cmd/addr-length field width.
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- req_valid_i / req_ready_o  in/out  NUM_REQ  descriptor handshake per requester
- req_desc_i  in  NUM_REQ*DW  descriptors; DW = 11+CAL_WIDTH+TRL_WIDTH, packed {rwm, spm[1:0], snm[3:0], tdtb[1:0], rdtb[1:0], cal, trl}
- req_tx_valid_i / req_tx_ready_o  in/out  NUM_REQ  tx word handshake
- req_tx_data_i  in  NUM_REQ*DATA_WIDTH  tx words
- req_rx_valid_o / req_rx_ready_i  out/in  NUM_REQ  rx word handshake
- req_rx_data_o  out  DATA_WIDTH  rx word, shared by all requesters
- req_done_o  out  NUM_REQ  one-cycle completion pulse
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle
- rx_drop_o  out  1  pulse: rx word lost to backpressure
- timeout_o  out  1  pulse with req_done_o on watchdog abort
- core_st_o, core_trl_valid_o  out  1  core start / length load
- core_trl_o  out  TRL_WIDTH  length to load
- core_rwm_o, core_spm_o, core_snm_o, core_tdtb_o, core_rdtb_o, core_cal_o  out  1/2/4/2/2/CAL_WIDTH  latched config
- core_busy_i, core_last_i  in  1  core status
- core_tx_valid_o / core_tx_ready_i / core_tx_data_o  out/in/out  1/1/DATA_WIDTH  tx stream to core
- core_rx_valid_i / core_rx_ready_o / core_rx_data_i  in/out/in  1/1/DATA_WIDTH  rx stream from core

Behaviour:
- Reset (rst_n_i=0 at clk edge): FSM=IDLE, all outputs 0, RR pointer favours req 0, config regs 0. Applies mid-transfer; core_st_o drops on the next cycle.
- FSM states IDLE, LOAD, START, RUN, DRAIN, DONE.
- IDLE:
  - If any req_valid_i, pick the first set bit at or after the RR pointer (wrapping).
  - Assert req_ready_o[g] for exactly this cycle, latch the descriptor, set grant_o, go to LOAD.
- LOAD: core_trl_valid_o=1 and core_trl_o=trl for exactly one cycle; go to START.
- START: core_st_o rises; go to RUN.
- core_st_o is held 1 throughout START and RUN, and is 0 in all other states.
- RUN:
  - core_tx_valid_o=req_tx_valid_i[g]; core_tx_data_o=word g; req_tx_ready_o[g]=core_tx_ready_i; other requesters' tx_ready=0.
  - req_rx_valid_o[g]=core_rx_valid_i; core_rx_ready_o=req_rx_ready_i[g]; req_rx_data_o=core_rx_data_i.
  - On core_last_i=1, go to DRAIN.
- DRAIN:
  - core_st_o=0; the rx path stays routed.
  - Minimum 2 cycles, then wait for core_busy_i=0.
  - Go to DONE.
- DONE: req_done_o[g] pulses one cycle; RR pointer = g+1 mod NUM_REQ; grant_o=0; go to IDLE.
- Latency: IDLE accept to core_st_o high = 2 cycles. Back-to-back transfers have 1 IDLE cycle between DONE and the next accept.
- rx backpressure: the core cannot stall. core_rx_valid_i=1 with req_rx_ready_i[g]=0 discards the word and pulses rx_drop_o.
- Config outputs are stable from LOAD until IDLE re-entry. req_valid_i changes during a grant are ignored.
- A simultaneous core_last_i in START is honoured: go to DRAIN next cycle.
- Requester with trl=0: the transfer still runs a single frame.

Optional Feature:
- Macro: SPI_XFER_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entering RUN and on every tx or rx handshake, and increments in RUN and DRAIN.
  - On reaching TIMEOUT_CYC, force DRAIN→DONE, ignoring core_busy_i after 2 cycles.
  - timeout_o pulses with req_done_o.
- When undefined: no counter; timeout_o tied 0.

Test Plan:
- Req0 only, desc std spi, rwm=0, trl=3, tdtb=8b, tx words 0xA5,0x3C,0x0F,0xF0 → core_trl_valid_o 1 cycle with 3, core_st_o high 2 cycles after accept, 4 tx handshakes, req_done_o[0] once, grant_o=0 after.
- Req0 and req1 valid in the same cycle, repeated 4 times → grants alternate 0,1,0,1; never two grant bits set.
- Read, quad, rwm=1, trl=2, cal=1, core returns 0x11223344 → req_rx_valid_o[1] with that data, rx_drop_o=0.
- Same read with req_rx_ready_i=0 → rx_drop_o pulses once per returned word; transfer still completes.
- rst_n_i low for 1 cycle mid-RUN → next cycle core_st_o=0, grant_o=0, FSM IDLE; next accept goes to req 0.
- With SPI_XFER_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, core never asserts last → timeout_o and req_done_o pulse 100 cycles after the last handshake.
